zap_copro_dispatch: RTL and testbench
=====================================

ZAP_COPRO_DISPATCH -- requirements
Module: zap_copro_dispatch

Interface
- REQ-001 SHALL have parameter CP_PRESENT, default 16'h8000, meaning bit n=1 marks coprocessor n as attached.
- REQ-002 SHALL have parameter CP_USR_OK, default 16'h0000, meaning bit n=1 permits USR-mode access to coprocessor n.
- REQ-003 SHALL have parameter TIMEOUT, default 255, range 1..65535, meaning the maximum number of BUSY cycles before abort.
- REQ-004 SHALL use clock i_clk and reset i_reset (synchronous, active-high); both are 1-bit inputs.
- REQ-005 SHALL have i_instruction, input, 35 bits: decoded instruction; bits [34:32] are the extension tag.
- REQ-006 SHALL have i_valid, input, 1 bit; i_cpsr_ff_t, input, 1 bit; i_cpsr_ff_mode, input, 5 bits; i_irq and i_fiq, input, 1 bit each.
- REQ-007 SHALL have i_clear_from_writeback, i_data_stall, i_clear_from_alu, i_stall_from_shifter and i_stall_from_issue, inputs, 1 bit each, in priority order high to low.
- REQ-008 SHALL have i_pipeline_dav, input, 1 bit: high while any downstream stage holds a valid instruction.
- REQ-009 SHALL have i_copro_done, input, 16 bits: bit n is the done strobe from coprocessor n.
- REQ-010 SHALL have o_instruction (35), o_valid (1), o_irq (1), o_fiq (1) and o_stall_from_decode (1), all outputs.
- REQ-011 SHALL have o_und, output, 1 bit: marks the accompanying o_instruction as an undefined-instruction trap.
- REQ-012 SHALL have o_copro_dav_ff, output, 16 bits, one-hot: registered request to coprocessor n.
- REQ-013 SHALL have o_copro_word_ff, output, 32 bits: registered instruction word sent to the coprocessor.

Function
- REQ-014 SHALL classify a cycle as a coprocessor cycle when i_valid=1, i_cpsr_ff_t=0, i_instruction[34:32]=0 and i_instruction[31:0] matches MRC, MCR, LDC, STC or CDP; in that case cp=i_instruction[11:8].
- REQ-015 SHALL treat a coprocessor cycle as permitted when CP_PRESENT[cp]=1 and either i_cpsr_ff_mode!=USR or CP_USR_OK[cp]=1.
- REQ-016 SHALL implement the states IDLE, DRAIN and BUSY, plus a busy counter of width clog2(TIMEOUT+1).
- REQ-017 IDLE, non-coprocessor cycle: SHALL be transparent (outputs equal inputs), with o_und=0, o_stall_from_decode=0 and dav next=0.
- REQ-018 IDLE, unpermitted coprocessor cycle: SHALL be transparent, with o_und=1, no stall and no state change.
- REQ-019 IDLE, permitted coprocessor cycle: SHALL drive o_stall_from_decode=1, o_valid=0, o_irq=o_fiq=0 and o_instruction={4'b1111,31'd0}.
  - If i_pipeline_dav=1, next state is DRAIN.
  - If i_pipeline_dav=0, next state is BUSY, word next=i_instruction[31:0], dav next=(1<<cp), and counter next=0.
- REQ-020 DRAIN: SHALL drive the same outputs as REQ-019 and SHALL move to BUSY, loading word, dav and counter as in REQ-019, in the first cycle i_pipeline_dav=0.
- REQ-021 BUSY: SHALL hold the stall with o_valid=0 and o_irq=o_fiq=0, hold word and dav, and increment the counter each advancing cycle.
- REQ-022 BUSY, (i_copro_done & o_copro_dav_ff)!=0: SHALL drop the stall in that cycle, set dav next=0 and word next=0, and move to IDLE.
  - Done bits of non-selected coprocessors SHALL be ignored.
- REQ-023 BUSY, counter==TIMEOUT-1 with no done: SHALL drop the stall, set o_valid=i_valid, o_instruction=i_instruction and o_und=1, set dav next=0, and move to IDLE.
- REQ-024 Done and timeout in the same cycle: done SHALL win and o_und SHALL be 0.
- REQ-025 State, word, dav and counter SHALL update only when no clear or stall input is active.
  - i_clear_from_writeback or i_clear_from_alu SHALL force state=IDLE, dav=0 and counter=0.
  - i_data_stall, i_stall_from_shifter or i_stall_from_issue SHALL hold all registers, subject to the priority order of REQ-007.
- REQ-026 o_copro_dav_ff SHALL never have more than one bit set.

Reset
- REQ-027 i_reset SHALL force state=IDLE, o_copro_dav_ff=0, o_copro_word_ff=0 and counter=0, taking priority over every other input.
- REQ-028 A reset in DRAIN or BUSY SHALL abandon the transaction, with no o_und and the stall released the next cycle.

Verification
- REQ-029 The bench SHALL cover: MCR to cp15 in SVC mode with i_pipeline_dav=0 -> next cycle o_copro_dav_ff=16'h8000 and word=instr; i_copro_done[15]=1 three cycles later -> stall drops in that cycle and dav=0 the cycle after.
- REQ-030 The bench SHALL cover: MRC to cp15 in USR mode with default parameters -> same cycle o_und=1, o_valid=1, no stall, dav stays 0.
- REQ-031 The bench SHALL cover: CDP to cp3 (absent) in SVC mode -> o_und=1, transparent pass-through.
- REQ-032 The bench SHALL cover: TIMEOUT=4 and no done -> BUSY lasts 4 cycles, then o_und=1 with the stall released in the 4th cycle.
- REQ-033 The bench SHALL cover: permitted access with i_pipeline_dav=1 for 2 cycles -> DRAIN for those 2 cycles, dav asserted on the 3rd clock edge.
- REQ-034 The bench SHALL cover: i_clear_from_writeback in BUSY together with i_copro_done[15]=0 -> next cycle IDLE and dav=0; i_copro_done[14]=1 while busy on cp15 -> ignored.

Source files
------------

// File: rtl/zap_copro_dispatch.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : zap_copro_dispatch
// Purpose  : Decode-stage coprocessor dispatcher. Detects MRC/MCR/LDC/STC/CDP,
//            checks presence/privilege, drains the pipeline, issues a one-hot
//            request to the selected coprocessor and waits for its done
//            strobe (or a timeout, which raises an undefined trap).
// Revision : 1.0 - initial release
// ============================================================================
module zap_copro_dispatch #(
  parameter logic [15:0] CP_PRESENT = 16'h8000,
  parameter logic [15:0] CP_USR_OK  = 16'h0000,
  parameter int          TIMEOUT    = 255
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [34:0] i_instruction,
  input  logic        i_valid,
  input  logic        i_cpsr_ff_t,
  input  logic [4:0]  i_cpsr_ff_mode,
  input  logic        i_irq,
  input  logic        i_fiq,
  input  logic        i_clear_from_writeback,
  input  logic        i_data_stall,
  input  logic        i_clear_from_alu,
  input  logic        i_stall_from_shifter,
  input  logic        i_stall_from_issue,
  input  logic        i_pipeline_dav,
  input  logic [15:0] i_copro_done,
  output logic [34:0] o_instruction,
  output logic        o_valid,
  output logic        o_irq,
  output logic        o_fiq,
  output logic        o_stall_from_decode,
  output logic        o_und,
  output logic [15:0] o_copro_dav_ff,
  output logic [31:0] o_copro_word_ff
);

  localparam int              CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]   c_last   = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0]   c_one    = CW'(1);
  localparam logic [4:0]      c_usr    = 5'b10000;
  localparam logic [34:0]     c_nop    = {4'b1111, 31'd0};

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRAIN = 2'd1;
  localparam logic [1:0] S_BUSY  = 2'd2;

  logic [1:0]    r_state, w_state_nxt;
  logic [CW-1:0] r_cnt,   w_cnt_nxt;
  logic [15:0]   r_dav,   w_dav_nxt;
  logic [31:0]   r_word,  w_word_nxt;

  // Instruction classification. CDP/MRC/MCR share 1110 in [27:24];
  // LDC/STC share 110 in [27:25]. Condition field is not examined.
  logic [31:0] w_word;
  logic [3:0]  w_cp;
  logic        w_cp_fmt, w_cp_cycle, w_permit, w_done, w_timeout;
  logic [15:0] w_cp_onehot;
  logic        w_flush, w_hold;

  assign w_word      = i_instruction[31:0];
  assign w_cp        = w_word[11:8];
  assign w_cp_fmt    = (w_word[27:24] == 4'b1110) || (w_word[27:25] == 3'b110);
  assign w_cp_cycle  = i_valid && !i_cpsr_ff_t && (i_instruction[34:32] == 3'd0) && w_cp_fmt;
  assign w_permit    = CP_PRESENT[w_cp] && ((i_cpsr_ff_mode != c_usr) || CP_USR_OK[w_cp]);
  assign w_cp_onehot = 16'h0001 << w_cp;
  // Only the selected coprocessor's done bit counts.
  assign w_done      = |(i_copro_done & r_dav);
  assign w_timeout   = (r_cnt == c_last);

  // Clear/stall priority: writeback clear > data stall > ALU clear > others.
  assign w_flush = i_clear_from_writeback || (!i_data_stall && i_clear_from_alu);
  assign w_hold  = i_data_stall || i_stall_from_shifter || i_stall_from_issue;

  assign o_copro_dav_ff  = r_dav;
  assign o_copro_word_ff = r_word;

  // State register plus request/counter registers, advancing only when unstalled.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_dav   <= '0;
      r_word  <= '0;
    end else if (w_flush) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_dav   <= '0;
    end else if (!w_hold) begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_dav   <= w_dav_nxt;
      r_word  <= w_word_nxt;
    end
  end

  // Next-state logic: launch, drain, wait for done or timeout.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_dav_nxt   = r_dav;
    w_word_nxt  = r_word;
    case (r_state)
      S_IDLE: begin
        w_dav_nxt = '0;
        if (w_cp_cycle && w_permit) begin
          if (i_pipeline_dav) begin
            w_state_nxt = S_DRAIN;
          end else begin
            w_state_nxt = S_BUSY;
            w_word_nxt  = w_word;
            w_dav_nxt   = w_cp_onehot;
            w_cnt_nxt   = '0;
          end
        end
      end
      S_DRAIN: begin
        if (!i_pipeline_dav) begin
          w_state_nxt = S_BUSY;
          w_word_nxt  = w_word;
          w_dav_nxt   = w_cp_onehot;
          w_cnt_nxt   = '0;
        end
      end
      S_BUSY: begin
        if (w_done) begin
          w_state_nxt = S_IDLE;
          w_dav_nxt   = '0;
          w_word_nxt  = '0;
        end else if (w_timeout) begin
          w_state_nxt = S_IDLE;
          w_dav_nxt   = '0;
        end else begin
          w_cnt_nxt   = r_cnt + c_one;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_dav_nxt   = '0;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Output logic: transparent unless stalling for a coprocessor transaction.
  always_comb begin
    o_instruction       = i_instruction;
    o_valid             = i_valid;
    o_irq               = i_irq;
    o_fiq               = i_fiq;
    o_und               = 1'b0;
    o_stall_from_decode = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_cp_cycle) begin
          if (w_permit) begin
            o_stall_from_decode = 1'b1;
            o_valid             = 1'b0;
            o_irq               = 1'b0;
            o_fiq               = 1'b0;
            o_instruction       = c_nop;
          end else begin
            o_und = 1'b1;
          end
        end
      end
      S_DRAIN: begin
        o_stall_from_decode = 1'b1;
        o_valid             = 1'b0;
        o_irq               = 1'b0;
        o_fiq               = 1'b0;
        o_instruction       = c_nop;
      end
      S_BUSY: begin
        o_stall_from_decode = 1'b1;
        o_valid             = 1'b0;
        o_irq               = 1'b0;
        o_fiq               = 1'b0;
        o_instruction       = c_nop;
        if (w_done) begin
          // Coprocessor consumed the instruction; release decode.
          o_stall_from_decode = 1'b0;
        end else if (w_timeout) begin
          // No response: hand the instruction on as an undefined trap.
          o_stall_from_decode = 1'b0;
          o_valid             = i_valid;
          o_irq               = i_irq;
          o_fiq               = i_fiq;
          o_instruction       = i_instruction;
          o_und               = 1'b1;
        end
      end
      default: begin
        o_stall_from_decode = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_zap_copro_dispatch.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_zap_copro_dispatch
// Purpose  : Directed self-checking bench for zap_copro_dispatch (TIMEOUT=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_zap_copro_dispatch;

  logic        clk = 1'b0;
  logic        rst;
  logic [34:0] instr;
  logic        valid, t_bit, irq, fiq;
  logic [4:0]  mode;
  logic        clr_wb, dstall, clr_alu, st_shf, st_iss, pdav;
  logic [15:0] done;
  logic [34:0] o_instr;
  logic        o_valid, o_irq, o_fiq, o_stall, o_und;
  logic [15:0] o_dav;
  logic [31:0] o_word;

  int total = 0;
  int bad   = 0;

  localparam logic [34:0] NOP  = {4'b1111, 31'd0};
  localparam logic [4:0]  SVC  = 5'b10011;
  localparam logic [4:0]  USR  = 5'b10000;
  localparam logic [31:0] MCR15 = 32'hEE010F10;
  localparam logic [31:0] MRC15 = 32'hEE110F10;
  localparam logic [31:0] CDP3  = 32'hEE000300;
  localparam logic [31:0] LDC15 = 32'hED900F00;
  localparam logic [31:0] MOV   = 32'hE1A00001;

  always #5 clk = ~clk;

  zap_copro_dispatch #(
    .CP_PRESENT(16'h8000),
    .CP_USR_OK (16'h0000),
    .TIMEOUT   (4)
  ) dut (
    .i_clk                 (clk),
    .i_reset               (rst),
    .i_instruction         (instr),
    .i_valid               (valid),
    .i_cpsr_ff_t           (t_bit),
    .i_cpsr_ff_mode        (mode),
    .i_irq                 (irq),
    .i_fiq                 (fiq),
    .i_clear_from_writeback(clr_wb),
    .i_data_stall          (dstall),
    .i_clear_from_alu      (clr_alu),
    .i_stall_from_shifter  (st_shf),
    .i_stall_from_issue    (st_iss),
    .i_pipeline_dav        (pdav),
    .i_copro_done          (done),
    .o_instruction         (o_instr),
    .o_valid               (o_valid),
    .o_irq                 (o_irq),
    .o_fiq                 (o_fiq),
    .o_stall_from_decode   (o_stall),
    .o_und                 (o_und),
    .o_copro_dav_ff        (o_dav),
    .o_copro_word_ff       (o_word)
  );

  task automatic chk(input string tag, input logic [34:0] obs, input logic [34:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] w, input logic v, input logic [4:0] m);
    instr = {3'b000, w};
    valid = v;
    mode  = m;
  endtask

  initial begin
    rst = 1'b1; instr = '0; valid = 1'b0; t_bit = 1'b0; irq = 1'b0; fiq = 1'b0;
    mode = SVC; clr_wb = 1'b0; dstall = 1'b0; clr_alu = 1'b0; st_shf = 1'b0;
    st_iss = 1'b0; pdav = 1'b0; done = '0;

    // Reset state
    tick(); tick();
    #1;
    chk("rst_dav",   o_dav,   '0);
    chk("rst_word",  o_word,  '0);
    chk("rst_stall", o_stall, '0);
    rst = 1'b0;

    // Ordinary instruction passes straight through
    drive(MOV, 1'b1, SVC); irq = 1'b1; #1;
    chk("mov_instr", o_instr, {3'b000, MOV});
    chk("mov_valid", o_valid, 1'b1);
    chk("mov_irq",   o_irq,   1'b1);
    chk("mov_und",   o_und,   1'b0);
    chk("mov_stall", o_stall, 1'b0);
    tick(); irq = 1'b0;
    chk("mov_dav", o_dav, '0);

    // MRC cp15 from USR: privilege trap, transparent
    drive(MRC15, 1'b1, USR); #1;
    chk("usr_und",   o_und,   1'b1);
    chk("usr_valid", o_valid, 1'b1);
    chk("usr_stall", o_stall, 1'b0);
    chk("usr_instr", o_instr, {3'b000, MRC15});
    tick();
    chk("usr_dav", o_dav, '0);

    // CDP to absent cp3: trap, transparent
    drive(CDP3, 1'b1, SVC); #1;
    chk("cdp3_und",   o_und,   1'b1);
    chk("cdp3_instr", o_instr, {3'b000, CDP3});
    chk("cdp3_stall", o_stall, 1'b0);
    tick();
    chk("cdp3_dav", o_dav, '0);

    // MCR cp15 in SVC with empty pipeline, done in third busy cycle
    drive(MCR15, 1'b1, SVC); irq = 1'b1; #1;
    chk("mcr_stall", o_stall, 1'b1);
    chk("mcr_valid", o_valid, 1'b0);
    chk("mcr_irq",   o_irq,   1'b0);
    chk("mcr_nop",   o_instr, NOP);
    tick(); irq = 1'b0;
    chk("mcr_dav",   o_dav,   16'h8000);
    chk("mcr_word",  o_word,  MCR15);
    chk("mcr_b1",    o_stall, 1'b1);
    tick();
    chk("mcr_b2",    o_stall, 1'b1);
    tick();
    done = 16'h8000; #1;
    chk("mcr_done_stall", o_stall, 1'b0);
    chk("mcr_done_und",   o_und,   1'b0);
    tick(); done = '0; valid = 1'b0; #1;
    chk("mcr_post_dav",   o_dav,   '0);
    chk("mcr_post_word",  o_word,  '0);

    // Foreign done bit ignored, then writeback clear aborts
    drive(MCR15, 1'b1, SVC);
    tick();
    done = 16'h4000; #1;
    chk("cp14_ignored", o_stall, 1'b1);
    tick();
    chk("cp14_dav", o_dav, 16'h8000);
    done = '0; clr_wb = 1'b1;
    tick(); clr_wb = 1'b0; valid = 1'b0; #1;
    chk("clr_dav",   o_dav,   '0);
    chk("clr_stall", o_stall, 1'b0);

    // Timeout after four busy cycles
    drive(MCR15, 1'b1, SVC);
    tick();
    chk("to_b1", o_stall, 1'b1);
    tick();
    chk("to_b2", o_stall, 1'b1);
    tick();
    chk("to_b3", o_stall, 1'b1);
    chk("to_b3_und", o_und, 1'b0);
    tick();
    chk("to_b4_stall", o_stall, 1'b0);
    chk("to_b4_und",   o_und,   1'b1);
    chk("to_b4_valid", o_valid, 1'b1);
    chk("to_b4_instr", o_instr, {3'b000, MCR15});
    tick(); valid = 1'b0; #1;
    chk("to_dav", o_dav, '0);

    // Issue stall freezes the busy counter; ALU clear then aborts
    drive(MCR15, 1'b1, SVC);
    tick();
    st_iss = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    chk("hold_dav", o_dav, 16'h8000);
    chk("hold_und", o_und, 1'b0);
    st_iss = 1'b0; clr_alu = 1'b1;
    tick(); clr_alu = 1'b0; valid = 1'b0; #1;
    chk("alu_clr_dav", o_dav, '0);

    // LDC cp15 waits in DRAIN for two cycles
    drive(LDC15, 1'b1, SVC); pdav = 1'b1; #1;
    chk("drn_stall0", o_stall, 1'b1);
    tick();
    chk("drn_dav1",   o_dav,   '0);
    chk("drn_stall1", o_stall, 1'b1);
    chk("drn_nop1",   o_instr, NOP);
    tick();
    chk("drn_dav2",   o_dav,   '0);
    pdav = 1'b0;
    tick();
    chk("drn_dav3",   o_dav,   16'h8000);
    chk("drn_word3",  o_word,  LDC15);
    done = 16'h8000; #1;
    chk("drn_done",   o_stall, 1'b0);
    tick(); done = '0; valid = 1'b0; #1;
    chk("drn_end_dav", o_dav, '0);

    // Reset while busy abandons the transaction
    drive(MCR15, 1'b1, SVC);
    tick();
    rst = 1'b1;
    tick(); rst = 1'b0; valid = 1'b0; #1;
    chk("rb_dav",   o_dav,   '0);
    chk("rb_word",  o_word,  '0);
    chk("rb_stall", o_stall, 1'b0);
    chk("rb_und",   o_und,   1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Safety net against a hung run
  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
